ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 92 +++++++++
 tb/tb_ram_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port RAM between a data and an instruction
//            requester. Data wins by default. A bounded streak counter keeps a
//            waiting instruction fetch from starving.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] c_max_streak = 4'(MAX_DSTREAK);

  logic [3:0] streak_q, streak_d;
  logic       d_rvalid_q, i_rvalid_q;
  logic       w_force_i;

  // The streak clears asynchronously, so during reset arbitration behaves as
  // if no data grants had accumulated.
  assign w_force_i = i_req && (streak_q >= c_max_streak);
  assign d_gnt     = d_req && !w_force_i;
  assign i_gnt     = i_req && !d_gnt;

  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && (streak_q < c_max_streak)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_be    = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (d_gnt) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt) begin
      m_req   = 1'b1;
      m_addr  = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q   <= 4'd0;
      d_rvalid_q <= 1'b0;
      i_rvalid_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      d_rvalid_q <= d_gnt;
      i_rvalid_q <= i_gnt;
    end
  end

  assign d_rvalid = d_rvalid_q;
  assign i_rvalid = i_rvalid_q;
  assign d_rdata  = m_rdata;
  assign i_rdata  = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter with an attached RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int MAX = 4;

  logic        clk, rst_n;
  logic        d_req, d_we, i_req;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic        d_gnt, d_rvalid, i_gnt, i_rvalid;
  logic [31:0] d_rdata, i_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  ram_port_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached single-port RAM: 64 words, one-cycle read latency, cleared by reset.
  logic [31:0] ram [64];
  logic [31:0] ram_rd;
  assign m_rdata = ram_rd;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++) ram[w] <= 32'd0;
    end else if (m_req) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ram[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        ram_rd <= ram[m_addr[7:2]];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] ref_mem [64];
  int          d_run;
  logic        prev_d, prev_i, prev_rd_d, prev_rd_i;
  logic [31:0] exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 64; w++) ref_mem[w] = 32'd0;
    d_run = 0; prev_d = 0; prev_i = 0; prev_rd_d = 0; prev_rd_i = 0;
  endtask

  // One arbitration cycle: drive at negedge, check against the model, advance it.
  task automatic step(input logic dr, input logic we, input logic [3:0] be,
                      input logic [31:0] da, input logic [31:0] wd,
                      input logic ir, input logic [31:0] ia);
    logic iw, dw;
    @(negedge clk);
    d_req = dr; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
    i_req = ir; i_addr = ia;
    #1;
    iw = ir && (!dr || d_run >= MAX);
    dw = dr && !iw;
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, dw});
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, iw});
    chk("m_req", {31'd0, m_req}, {31'd0, dw || iw});
    chk("m_we", {31'd0, m_we}, {31'd0, dw && we});
    chk("m_be", {28'd0, m_be}, dw ? {28'd0, be} : 32'd0);
    chk("m_addr", m_addr, dw ? da : (iw ? ia : 32'd0));
    chk("m_wdata", m_wdata, dw ? wd : 32'd0);
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, prev_d});
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, prev_i});
    if (prev_rd_d) chk("d_rdata", d_rdata, exp_rdata);
    if (prev_rd_i) chk("i_rdata", i_rdata, exp_rdata);
    prev_d = dw; prev_i = iw;
    prev_rd_d = dw && !we; prev_rd_i = iw;
    if (dw) exp_rdata = ref_mem[da[7:2]];
    else if (iw) exp_rdata = ref_mem[ia[7:2]];
    if (dw && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[da[7:2]][8*b +: 8] = wd[8*b +: 8];
    d_run = (ir && dw) ? ((d_run + 1 > MAX) ? MAX : d_run + 1) : 0;
  endtask

  typedef struct {
    logic dr; logic we; logic [3:0] be; logic [31:0] da; logic [31:0] wd;
    logic ir; logic [31:0] ia;
    logic ed; logic ei; logic emr; logic emw; logic [3:0] emb;
    logic [31:0] ema; logic [31:0] emd;
  } vec_t;

  vec_t tbl [10];
  logic [0:9] pat37;
  logic [0:8] pat39;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 4'hA, 32'h55, 32'hCAFE, 1'b0, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 4'hF, 32'h30, 32'h1111, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 4'h3, 32'h20, 32'h12345678, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 32'h20, 32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h20, 32'hFFFFFFFF};
    tbl[8] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    pat37 = 10'b1111011110;
    pat39 = 9'b111111110;

    // Reset state
    rst_n = 1'b0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0; i_req = 0; i_addr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("reset_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    chk("reset_m_req", {31'd0, m_req}, 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      step(tbl[v].dr, tbl[v].we, tbl[v].be, tbl[v].da, tbl[v].wd, tbl[v].ir, tbl[v].ia);
      chk($sformatf("tbl%0d_d_gnt", v), {31'd0, d_gnt}, {31'd0, tbl[v].ed});
      chk($sformatf("tbl%0d_i_gnt", v), {31'd0, i_gnt}, {31'd0, tbl[v].ei});
      chk($sformatf("tbl%0d_m_req", v), {31'd0, m_req}, {31'd0, tbl[v].emr});
      chk($sformatf("tbl%0d_m_we", v), {31'd0, m_we}, {31'd0, tbl[v].emw});
      chk($sformatf("tbl%0d_m_be", v), {28'd0, m_be}, {28'd0, tbl[v].emb});
      chk($sformatf("tbl%0d_m_addr", v), m_addr, tbl[v].ema);
      chk($sformatf("tbl%0d_m_wdata", v), m_wdata, tbl[v].emd);
    end

    // Both requesters held high: D,D,D,D,I,D,D,D,D,I
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h8);
      chk($sformatf("seq_streak_c%0d", c), {31'd0, d_gnt}, {31'd0, pat37[c]});
    end

    // i_req dropping one cycle clears the streak
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, (c != 3), 32'h4);
      chk($sformatf("seq_drop_c%0d", c), {31'd0, d_gnt}, {31'd0, pat39[c]});
    end

    // Reset pulsed in the cycle after a data grant, with streak at 3
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_reset_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    chk("reset_gnt_d", {31'd0, d_gnt}, 32'd1);
    chk("reset_gnt_i", {31'd0, i_gnt}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_reset_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h0);
      chk($sformatf("post_reset_c%0d", c), {31'd0, i_gnt}, {31'd0, c == 4});
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 9) < 6), $urandom_range(0, 1), 4'($urandom),
           {24'd0, 6'($urandom), 2'b00}, $urandom,
           ($urandom_range(0, 9) < 6), {24'd0, 6'($urandom), 2'b00});
    end
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
